sd_block_read_arbiter: RTL and testbench

- Shares the single `sd_card` SPI block-read controller between two requesters, e.g. a text-scan FSM and a display or debug reader.
- Arbitrates round-robin, issues the one-cycle `rd_req` with the latched block address, and counts the 512 `sd_valid` bytes into the shared 512x8 SRAM.
- Ends each transfer with a `done` pulse, or an `err` pulse on stall or card loss.
- Sits between requester FSMs and the `sd_card`/`sram` pair; runs on the system clock after SD init.

---
 rtl/sd_block_read_arbiter_if.sv | 39 +++
 rtl/sd_block_read_arbiter.sv | 119 +++++++++++
 tb/tb_sd_block_read_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_block_read_arbiter_if.sv
// ----------------------------------------------------------------------------
// sd_block_read_arbiter_if
// Bundles the requester, sd_card and SRAM signals of the block-read arbiter.
//   master : requester/sd_card side (drives requests, SD byte stream, init)
//   slave  : arbiter side (drives grants, completion pulses, SD request, SRAM)
// ----------------------------------------------------------------------------
interface sd_block_read_arbiter_if;
    logic        init_finished;
    logic        req0;
    logic [31:0] addr0;
    logic        req1;
    logic [31:0] addr1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic        err0;
    logic        err1;
    logic        sd_rd_req;
    logic [31:0] sd_blk_addr;
    logic        sd_valid;
    logic [7:0]  sd_dout;
    logic        sram_we;
    logic [8:0]  sram_addr;
    logic [7:0]  sram_din;
    logic        busy;

    modport master (
        output init_finished, req0, addr0, req1, addr1, sd_valid, sd_dout,
        input  gnt0, gnt1, done0, done1, err0, err1, sd_rd_req, sd_blk_addr,
               sram_we, sram_addr, sram_din, busy
    );

    modport slave (
        input  init_finished, req0, addr0, req1, addr1, sd_valid, sd_dout,
        output gnt0, gnt1, done0, done1, err0, err1, sd_rd_req, sd_blk_addr,
               sram_we, sram_addr, sram_din, busy
    );
endinterface

// File: rtl/sd_block_read_arbiter.sv
// ----------------------------------------------------------------------------
// sd_block_read_arbiter
// Shares one sd_card block-read controller between two requesters. Arbitrates
// round-robin, issues a one-cycle rd_req with the latched block address,
// streams the returned bytes into the shared SRAM and ends each transfer with
// a done pulse (all bytes written) or an err pulse (byte stall or card loss).
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      sd_block_read_arbiter_if.slave: requests/grants, done/err pulses,
//            sd_card rd_req/block_addr/valid/dout, SRAM we/addr/din, busy
// ----------------------------------------------------------------------------
module sd_block_read_arbiter #(
    parameter int BLK_BYTES      = 512,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sd_block_read_arbiter_if.slave bus
);
    localparam int            TW        = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [9:0]    LAST_BYTE = 10'(BLK_BYTES - 1);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ISSUE, S_XFER, S_DONE, S_ABRT
    } state_t;

    state_t        r_state, w_next;
    logic          r_owner, r_last, r_seen_init;
    logic [9:0]    r_byte_cnt;
    logic [TW-1:0] r_tout_cnt;
    logic [31:0]   r_addr;
    logic          w_win, w_active;

    // Round-robin pick: a lone requester wins, a tie goes to the one not
    // served last time.
    always_comb begin
        w_win = bus.req1;
        if (bus.req0 && bus.req1) w_win = ~r_last;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_INIT;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:  if (bus.init_finished) w_next = S_IDLE;
            S_IDLE: begin
                if (!bus.init_finished)         w_next = S_INIT;
                else if (bus.req0 || bus.req1)  w_next = S_ISSUE;
            end
            S_ISSUE: w_next = bus.init_finished ? S_XFER : S_ABRT;
            S_XFER: begin
                // Card loss wins over completion on the same cycle.
                if (!bus.init_finished)                         w_next = S_ABRT;
                else if (bus.sd_valid && r_byte_cnt == LAST_BYTE) w_next = S_DONE;
                else if (!bus.sd_valid && r_tout_cnt == TOUT_LAST) w_next = S_ABRT;
            end
            S_DONE:  w_next = S_IDLE;
            S_ABRT:  w_next = S_IDLE;
            default: w_next = S_INIT;
        endcase
    end

    // Grant bookkeeping, byte counter and stall timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_byte_cnt  <= '0;
            r_tout_cnt  <= '0;
            r_addr      <= '0;
            r_seen_init <= 1'b0;
        end else begin
            if (r_state == S_INIT && bus.init_finished) r_seen_init <= 1'b1;
            if (r_state == S_IDLE && w_next == S_ISSUE) begin
                r_owner    <= w_win;
                r_last     <= w_win;
                r_addr     <= w_win ? bus.addr1 : bus.addr0;
                r_byte_cnt <= '0;
                r_tout_cnt <= '0;
            end else if (r_state == S_XFER) begin
                if (bus.sd_valid) begin
                    r_byte_cnt <= r_byte_cnt + 10'd1;
                    r_tout_cnt <= '0;
                end else begin
                    r_tout_cnt <= r_tout_cnt + TW'(1);
                end
            end
        end
    end

    // Outputs
    always_comb begin
        w_active        = (r_state == S_ISSUE) || (r_state == S_XFER) ||
                          (r_state == S_DONE)  || (r_state == S_ABRT);
        bus.gnt0        = w_active && !r_owner;
        bus.gnt1        = w_active &&  r_owner;
        bus.done0       = (r_state == S_DONE) && !r_owner;
        bus.done1       = (r_state == S_DONE) &&  r_owner;
        bus.err0        = (r_state == S_ABRT) && !r_owner;
        bus.err1        = (r_state == S_ABRT) &&  r_owner;
        bus.sd_rd_req   = (r_state == S_ISSUE);
        bus.sd_blk_addr = r_addr;
        bus.sram_we     = bus.sd_valid && (r_state == S_XFER);
        bus.sram_addr   = r_byte_cnt[8:0];
        // Data bus is held at zero outside XFER so nothing leaks through in reset.
        bus.sram_din    = (r_state == S_XFER) ? bus.sd_dout : 8'd0;
        // Waiting for the very first init after reset is not busy; an init loss
        // later on (INIT reached again) is.
        bus.busy        = (r_state != S_IDLE) && !((r_state == S_INIT) && !r_seen_init);
    end
endmodule

// File: tb/tb_sd_block_read_arbiter.sv
module tb_sd_block_read_arbiter;
    localparam int BLK = 512;
    localparam int TO  = 100;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sd_block_read_arbiter_if bus ();

    sd_block_read_arbiter #(.BLK_BYTES(BLK), .TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_ref = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {6'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1,
                bus.sd_rd_req, bus.sd_blk_addr, bus.sram_we, bus.sram_addr,
                bus.sram_din, bus.busy};
    endfunction

    // The two grants must never be high together.
    always @(negedge clk)
        if (reset_n && (bus.gnt0 || bus.gnt1)) chk("gnt_exclusive", bus.gnt0 & bus.gnt1, 0);

    // Wait (bounded) until the ISSUE cycle; returns at its falling edge.
    task automatic wait_issue(output bit seen);
        int waited = 0;
        seen = 0;
        while (!seen && waited < 20) begin
            @(negedge clk);
            if (bus.sd_rd_req) seen = 1;
            else begin @(posedge clk); #1; waited++; end
        end
    endtask

    // One transfer as seen from the sd_card side: check the grant, stream
    // nbytes (BLK => expect done, fewer => expect a timeout err), check release.
    task automatic run_xfer(input bit exp_own, input logic [31:0] exp_addr,
                            input int nbytes, input int gapmax, input bit idx_data,
                            output int t_iss);
        bit seen;
        int badw, waited;
        logic [7:0] d;
        wait_issue(seen);
        t_iss = cyc;
        chk("issue_seen", seen, 1);
        if (!seen) return;
        chk("gnt_owner", {bus.gnt1, bus.gnt0}, exp_own ? 2'b10 : 2'b01);
        chk("blk_addr", bus.sd_blk_addr, exp_addr);
        chk("busy_issue", bus.busy, 1);
        // Later address changes must be ignored; the owner may drop its request.
        bus.addr0 = ~exp_addr;
        bus.addr1 = ~exp_addr;
        if (exp_own) bus.req1 = 0; else bus.req0 = 0;
        @(posedge clk); #1;
        t_ref = cyc;
        @(negedge clk);
        chk("rd_req_one_cycle", bus.sd_rd_req, 0);
        @(posedge clk); #1;
        badw = 0;
        for (int i = 0; i < nbytes; i++) begin
            int g = $urandom_range(gapmax, 0);
            for (int k = 0; k < g; k++) begin
                bus.sd_valid = 0;
                @(negedge clk);
                if (bus.sram_we) badw++;
                @(posedge clk); #1;
            end
            d = idx_data ? 8'(i) : 8'($urandom);
            bus.sd_valid = 1;
            bus.sd_dout  = d;
            @(negedge clk);
            if (!(bus.sram_we && bus.sram_addr == 9'(i) && bus.sram_din == d)) badw++;
            @(posedge clk); #1;
            t_ref = cyc;
        end
        bus.sd_valid = 0;
        chk("sram_write_path", badw, 0);
        if (nbytes == BLK) begin
            @(negedge clk);
            chk("done_pulse", {bus.done1, bus.done0, bus.err1, bus.err0},
                exp_own ? 4'b1000 : 4'b0100);
        end else begin
            seen = 0; waited = 0;
            while (!seen && waited < TO + 20) begin
                @(negedge clk);
                if (bus.err0 || bus.err1 || bus.done0 || bus.done1) seen = 1;
                else begin @(posedge clk); #1; waited++; end
            end
            chk("abort_seen", seen, 1);
            chk("err_pulse", {bus.done1, bus.done0, bus.err1, bus.err0},
                exp_own ? 4'b0010 : 4'b0001);
            chk("tout_latency", cyc - t_ref, TO);
        end
        chk("gnt_at_end", exp_own ? bus.gnt1 : bus.gnt0, 1);
        chk("blk_addr_hold", bus.sd_blk_addr, exp_addr);
        @(posedge clk); #1;
        bus.req0 = 0;
        bus.req1 = 0;
        @(negedge clk);
        chk("release", {bus.gnt1, bus.gnt0, bus.done1, bus.done0, bus.err1, bus.err0, bus.busy}, 0);
    endtask

    typedef struct {
        bit          r0;
        bit          r1;
        logic [31:0] a0;
        logic [31:0] a1;
        int          nbytes;
        bit          exp_own;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int t0, t_iss, viol;
        bit seen, m_last, r0, r1, own;
        logic [31:0] a0, a1;
        int nb;

        // Hand-derived arbitration table, starting from reset (last = 1).
        tbl[0] = '{1, 1, 32'h0000_1000, 32'h0000_2000, BLK, 0};
        tbl[1] = '{1, 1, 32'h0000_0011, 32'h0000_0022, BLK, 1};
        tbl[2] = '{1, 1, 32'h0000_0033, 32'h0000_0044, 10,  0};
        tbl[3] = '{0, 1, 32'h0000_0055, 32'h0000_0066, 0,   1};
        tbl[4] = '{0, 1, 32'h0000_0077, 32'h0000_0088, 3,   1};
        tbl[5] = '{1, 0, 32'h0000_0099, 32'h0000_00AA, BLK, 0};
        tbl[6] = '{1, 1, 32'h0000_00BB, 32'h0000_00CC, BLK, 1};

        // Reset with busy-looking inputs: every output must stay 0.
        reset_n = 0;
        bus.init_finished = 0;
        bus.req0 = 1; bus.addr0 = 32'h0000_2000;
        bus.req1 = 0; bus.addr1 = 32'h0000_3000;
        bus.sd_valid = 1; bus.sd_dout = 8'hA5;
        #3 chk("outs_in_reset", outs(), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        #1 chk("outs_after_reset", outs(), 0);

        // No grant while the card is not initialised.
        viol = 0;
        repeat (50) begin
            @(posedge clk); #1;
            bus.sd_valid = 1'($urandom);
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1 || bus.sd_rd_req || bus.sram_we) viol++;
        end
        chk("no_grant_before_init", viol, 0);
        @(posedge clk); #1;
        bus.sd_valid = 0;
        bus.init_finished = 1;
        t0 = cyc;
        run_xfer(0, 32'h0000_2000, BLK, 3, 1, t_iss);
        chk("grant_latency", t_iss - t0, 2);

        // Stall after 10 bytes: err0 after the timeout, stray strobe ignored.
        @(posedge clk); #1;
        bus.req0 = 1; bus.addr0 = 32'h0000_4000;
        run_xfer(0, 32'h0000_4000, 10, 2, 1, t_iss);
        @(posedge clk); #1;
        bus.sd_valid = 1; bus.sd_dout = 8'h5A;
        @(negedge clk);
        chk("stray_valid_no_write", bus.sram_we, 0);
        @(posedge clk); #1;
        bus.sd_valid = 0;

        // Card loss mid-transfer for requester 1.
        bus.req1 = 1; bus.addr1 = 32'h0001_0000;
        wait_issue(seen);
        chk("t5_issue", {seen, bus.gnt1}, 2'b11);
        @(posedge clk); #1;
        bus.sd_valid = 1;
        for (int i = 0; i < 20; i++) begin bus.sd_dout = 8'(i); @(posedge clk); #1; end
        bus.sd_valid = 0;
        bus.init_finished = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_err1", {bus.gnt1, bus.done1, bus.done0, bus.err1, bus.err0}, 5'b10010);
        @(posedge clk); #1;
        bus.req1 = 0;
        @(posedge clk); #1;
        bus.req1 = 1;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1 || bus.sd_rd_req || !bus.busy) viol++;
            @(posedge clk); #1;
        end
        chk("t5_held_in_init", viol, 0);
        bus.init_finished = 1;
        run_xfer(1, 32'h0001_0000, BLK, 1, 0, t_iss);

        // Asynchronous reset in the middle of a transfer.
        @(posedge clk); #1;
        bus.req0 = 1; bus.addr0 = 32'hCAFE_0000;
        wait_issue(seen);
        chk("t6_issue", seen, 1);
        @(posedge clk); #1;
        bus.sd_valid = 1;
        for (int i = 0; i < 100; i++) begin bus.sd_dout = 8'(i); @(posedge clk); #1; end
        #3 reset_n = 0;
        #1 chk("async_reset_outs", outs(), 0);
        viol = 0;
        repeat (5) begin
            @(negedge clk);
            if (outs() != 0) viol++;
        end
        chk("reset_hold_outs", viol, 0);
        @(posedge clk); #1;
        bus.sd_valid = 0; bus.req0 = 0;
        reset_n = 1;

        // Table: recovery from reset, then round-robin order and endings.
        for (int v = 0; v < 7; v++) begin
            @(posedge clk); #1;
            bus.req0 = tbl[v].r0; bus.addr0 = tbl[v].a0;
            bus.req1 = tbl[v].r1; bus.addr1 = tbl[v].a1;
            run_xfer(tbl[v].exp_own, tbl[v].exp_own ? tbl[v].a1 : tbl[v].a0,
                     tbl[v].nbytes, 2, 0, t_iss);
        end
        m_last = tbl[6].exp_own;

        // Random requests against the round-robin rule.
        for (int n = 0; n < 8; n++) begin
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r1 = 1;
            a0 = $urandom; a1 = $urandom;
            own = (r0 && r1) ? !m_last : r1;
            m_last = own;
            nb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 0)) : BLK;
            @(posedge clk); #1;
            bus.req0 = r0; bus.addr0 = a0;
            bus.req1 = r1; bus.addr1 = a1;
            run_xfer(own, own ? a1 : a0, nb, int'($urandom_range(3, 0)), 0, t_iss);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
